rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
Registered round-robin arbiter that sits directly downstream of the one-hot priority picker. Each cycle it rotates the request vector by a priority pointer and selects the first set bit with find_first_one. It then rotates the result back and registers it as a held grant. The grant persists until the owner releases it or a hold timeout fires, then priority advances past the last winner.

Parameters:
WIDTH, 8, number of requesters (≥2; need not be a power of two)
MSB, WIDTH-1, top index of request/grant vectors
IDX_W, $clog2(WIDTH), width of grant index and priority pointer
MAX_HOLD, 0, maximum cycles a grant may be held; 0 disables the timeout
FFO_IMPL, 6, IMPL value passed to the find_first_one instance

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req  input  [MSB:0]  request vector, level-sensitive, any number of bits set
release  input  1  current owner ends its grant this cycle
grant  output  [MSB:0]  registered one-hot grant; all-zero when idle
grant_valid  output  1  registered; equals |grant
grant_idx  output  [IDX_W-1:0]  registered binary index of the granted bit; 0 when idle
timeout  output  1  combinational; high in the final cycle of a grant forcibly ended by MAX_HOLD

Behaviour:
- Reset (rst=1 at an edge): grant=0, grant_valid=0, grant_idx=0, ptr=0, hold_cnt=0, state=IDLE. Rst overrides all other inputs, including mid-grant. timeout=0 while state=IDLE.
- State IDLE:
  - If |req, compute rot = req rotated right by ptr (modulo WIDTH), f = find_first_one(rot), cand = f rotated left by ptr.
  - At the edge, latch grant=cand, grant_idx=(ptr+pos(f)) mod WIDTH, hold_cnt=0, and go to GRANTED.
  - Latency is 1 cycle from req to grant.
  - If req=0, stay IDLE. release is ignored in IDLE.
- State GRANTED:
  - grant is held regardless of req; dropping req does not end a grant.
  - end = release | (MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1). timeout = end & ~release.
  - On end: ptr_next=(grant_idx+1) mod WIDTH, so index WIDTH-1 wraps to 0.
  - Re-arbitration on end uses ptr_next in the same cycle. If the candidate is nonzero, load it directly (back-to-back grant, no idle bubble) and clear hold_cnt. Otherwise go to IDLE with grant=0.
  - The releasing requester may win again only if it is the sole requester.
  - If there is no end, increment hold_cnt (saturating at MAX_HOLD-1).
- ptr changes only on end. It is never changed by reset-free idle cycles.
- Non-power-of-two WIDTH: rotation and pointer arithmetic are strictly modulo WIDTH, and unused encodings never appear on grant_idx.
- grant is always one-hot or zero. A grant is never issued to a bit whose req was 0 in the arbitration cycle.

Decomposition:
- Package arb_pkg: typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t, plus a function rotating a vector by a pointer modulo WIDTH, parameterised via the module.
- One sub-module, find_first_one (existing block), instantiated once with WIDTH and IMPL=FFO_IMPL on the rotated request vector.
- One-hot-to-index conversion stays local to the module.

Test Plan:
1. WIDTH=8, rst 2 cycles, then req=8'b0000_0100 → next cycle grant=8'b0000_0100, grant_idx=2, grant_valid=1; with no release the grant holds for 10 cycles.
2. ptr=0, req=8'b1010_0000 held → grant bit5. Pulse release → next cycle grant bit7 with no idle gap, and ptr becomes 6.
3. Wrap: after bit7 granted, req=8'b1000_0001, pulse release → grant bit0, ptr becomes 0. Release again with req=8'b1000_0001 → grant bit7 via ptr=1.
4. MAX_HOLD=4, req=8'b0000_0011, no release → bit0 granted for exactly 4 cycles with timeout=1 in cycle 4 only. Cycle 5 grant=bit1.
5. rst asserted while bit3 granted → next cycle grant=0, grant_idx=0, valid=0. Then req=8'hFF → grant bit0, showing ptr reset to 0.
6. release while idle with req=0 → no state change, timeout=0. req drops to 0 while bit4 granted → grant stays bit4 until release, then grant=0 and state IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and vector rotation helpers for the round-robin grant arbiter.
// Rotations are modulo a runtime width, so non-power-of-two requester counts wrap correctly.
package arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANTED = 1'b1} arb_state_t;

  localparam int ARB_MAX_W = 64;
  localparam int ARB_IDX_W = 6;

  // Rotate right by sh within the low w bits; sh must be below w.
  function automatic logic [ARB_MAX_W-1:0] rotate_right(
    input logic [ARB_MAX_W-1:0] vec,
    input logic [ARB_IDX_W:0]   sh,
    input logic [ARB_IDX_W:0]   w
  );
    logic [ARB_MAX_W-1:0] res;
    logic [ARB_IDX_W:0]   src;
    res = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      src = {1'b0, i[ARB_IDX_W-1:0]} + sh;
      if (src >= w) begin
        src = src - w;
      end else begin
        src = src;
      end
      if ({1'b0, i[ARB_IDX_W-1:0]} < w) begin
        res[i] = vec[src[ARB_IDX_W-1:0]];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic [ARB_MAX_W-1:0] rotate_left(
    input logic [ARB_MAX_W-1:0] vec,
    input logic [ARB_IDX_W:0]   sh,
    input logic [ARB_IDX_W:0]   w
  );
    logic [ARB_MAX_W-1:0] res;
    logic [ARB_IDX_W:0]   src;
    res = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      src = {1'b0, i[ARB_IDX_W-1:0]} + w - sh;
      if (src >= w) begin
        src = src - w;
      end else begin
        src = src;
      end
      if ({1'b0, i[ARB_IDX_W-1:0]} < w) begin
        res[i] = vec[src[ARB_IDX_W-1:0]];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_ffo.sv
// find_first_one: one-hot of the lowest set bit of vec (all-zero when vec is zero).
// IMPL 0 uses a priority scan; any other value uses the two's-complement isolate trick.
module find_first_one #(
  parameter int WIDTH = 8,
  parameter int IMPL  = 0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] first
);

  if (IMPL == 0) begin : g_scan
    always_comb begin
      first = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        first = vec[i] ? (WIDTH'(1) << i) : first;
      end
    end
  end else begin : g_isolate
    assign first = vec & (~vec + WIDTH'(1));
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with held grants and optional hold timeout.
// "release" is a reserved word in SystemVerilog, so the owner's release input is release_grant.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MSB      = WIDTH - 1,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int MAX_HOLD = 0,
  parameter int FFO_IMPL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSB:0]     req,
  input  logic             release_grant,
  output logic [MSB:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);

  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int                PW        = ARB_IDX_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  arb_state_t        state_r;
  arb_state_t        state_next;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  ptr_next;
  logic [IDX_W-1:0]  ptr_wrap_s;
  logic [IDX_W-1:0]  arb_ptr_s;
  logic [IDX_W-1:0]  cand_idx_s;
  logic [IDX_W-1:0]  grant_idx_next;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic [MSB:0]      rot_s;
  logic [MSB:0]      first_s;
  logic [MSB:0]      cand_s;
  logic [MSB:0]      grant_next;
  logic              cand_any_s;
  logic              hold_expired_s;
  logic              end_s;

  // On a grant end the search starts just past the outgoing winner, in the same cycle.
  assign ptr_wrap_s = (grant_idx == IDX_LAST) ? '0 : (grant_idx + IDX_W'(1));
  assign arb_ptr_s  = (state_r == ARB_GRANTED) ? ptr_wrap_s : ptr_r;

  assign rot_s = WIDTH'(rotate_right(ARB_MAX_W'(req), PW'(arb_ptr_s), PW'(WIDTH)));

  find_first_one #(
    .WIDTH(WIDTH),
    .IMPL (FFO_IMPL)
  ) u_ffo (
    .vec  (rot_s),
    .first(first_s)
  );

  assign cand_s     = WIDTH'(rotate_left(ARB_MAX_W'(first_s), PW'(arb_ptr_s), PW'(WIDTH)));
  assign cand_any_s = |first_s;

  always_comb begin
    cand_idx_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cand_idx_s = cand_idx_s | (cand_s[i] ? IDX_W'(i) : '0);
    end
  end

  assign hold_expired_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);
  assign end_s          = (state_r == ARB_GRANTED) && (release_grant || hold_expired_s);
  assign timeout        = (state_r == ARB_GRANTED) && hold_expired_s && !release_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      ARB_IDLE:    state_next = cand_any_s ? ARB_GRANTED : ARB_IDLE;
      ARB_GRANTED: state_next = (end_s && !cand_any_s) ? ARB_IDLE : ARB_GRANTED;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_next     = grant;
    grant_idx_next = grant_idx;
    ptr_next       = ptr_r;
    hold_cnt_next  = hold_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (cand_any_s) begin
          grant_next     = cand_s;
          grant_idx_next = cand_idx_s;
          hold_cnt_next  = '0;
        end else begin
          grant_next     = '0;
          grant_idx_next = '0;
        end
      end
      ARB_GRANTED: begin
        if (end_s) begin
          ptr_next       = ptr_wrap_s;
          hold_cnt_next  = '0;
          grant_next     = cand_any_s ? cand_s : '0;
          grant_idx_next = cand_any_s ? cand_idx_s : '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_r != HOLD_LAST)) begin
          hold_cnt_next = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_next = hold_cnt_r;
        end
      end
      default: begin
        grant_next     = '0;
        grant_idx_next = '0;
        ptr_next       = '0;
        hold_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr_r       <= '0;
      hold_cnt_r  <= '0;
    end else begin
      grant       <= grant_next;
      grant_valid <= |grant_next;
      grant_idx   <= grant_idx_next;
      ptr_r       <= ptr_next;
      hold_cnt_r  <= hold_cnt_next;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench: three arbiter configurations driven by shared stimulus and checked
// every cycle against a round-robin model, plus hand-computed expectations for key scenarios.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;

  logic [7:0] ga, gb;
  logic [4:0] gc;
  logic       va, vb, vc, ta, tb, tc;
  logic [2:0] ia, ib, ic;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.WIDTH(8), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .release_grant(rel),
    .grant(ga), .grant_valid(va), .grant_idx(ia), .timeout(ta));

  rr_grant_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req), .release_grant(rel),
    .grant(gb), .grant_valid(vb), .grant_idx(ib), .timeout(tb));

  rr_grant_arbiter #(.WIDTH(5), .MAX_HOLD(3), .FFO_IMPL(0)) dut_c (
    .clk(clk), .rst(rst), .req(req[4:0]), .release_grant(rel),
    .grant(gc), .grant_valid(vc), .grant_idx(ic), .timeout(tc));

  typedef struct {
    bit valid;
    int idx;
    int ptr;
    int cnt;
  } mstate_t;

  mstate_t ms [3];
  int      mw [3] = '{8, 8, 5};
  int      mh [3] = '{0, 4, 3};
  bit      armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin search: first requester at or after p, wrapping modulo w.
  function automatic int pick(input logic [7:0] r, input int p, input int w);
    for (int k = 0; k < w; k++) begin
      if (r[(p + k) % w]) return (p + k) % w;
    end
    return -1;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int w, input int mh_v,
                                    input logic [7:0] r, input bit rl, input bit rs);
    mstate_t n;
    int      p;
    n = s;
    if (rs) begin
      n.valid = 1'b0; n.idx = 0; n.ptr = 0; n.cnt = 0;
    end else if (!s.valid) begin
      p = pick(r, s.ptr, w);
      if (p >= 0) begin
        n.valid = 1'b1; n.idx = p; n.cnt = 0;
      end
    end else if (rl || (mh_v != 0 && s.cnt == mh_v - 1)) begin
      n.ptr = (s.idx + 1) % w;
      p = pick(r, n.ptr, w);
      n.cnt = 0;
      if (p >= 0) begin
        n.idx = p;
      end else begin
        n.valid = 1'b0; n.idx = 0;
      end
    end else if (mh_v != 0 && s.cnt < mh_v - 1) begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      ms[k] <= mstep(ms[k], mw[k], mh[k], req, rel, rst);
    end
  end

  task automatic cmp(input int k, input logic [7:0] g, input logic v,
                     input logic [7:0] ix, input logic to);
    logic [7:0] eg;
    logic       eto;
    eg  = ms[k].valid ? (8'h01 << ms[k].idx) : 8'h00;
    eto = ms[k].valid && !rel && (mh[k] != 0) && (ms[k].cnt == mh[k] - 1);
    check($sformatf("grant[%0d]", k), g, eg);
    check($sformatf("valid[%0d]", k), v, ms[k].valid);
    check($sformatf("idx[%0d]", k), ix, ms[k].valid ? ms[k].idx : 0);
    check($sformatf("timeout[%0d]", k), to, eto);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, ga, va, {5'b0, ia}, ta);
      cmp(1, gb, vb, {5'b0, ib}, tb);
      cmp(2, {3'b0, gc}, vc, {5'b0, ic}, tc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic grant and hold without release.
    rst = 1'b1; tick; tick;
    rst = 1'b0; req = 8'h04; tick;
    check("t1_grant", ga, 8'h04);
    check("t1_idx", ia, 3'd2);
    check("t1_valid", va, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t1_hold", ga, 8'h04);
    end

    // Back-to-back handover on release.
    rst = 1'b1; tick;
    rst = 1'b0; req = 8'hA0; tick;
    check("t2_first", ga, 8'h20);
    rel = 1'b1; tick;
    rel = 1'b0;
    check("t2_next", ga, 8'h80);
    check("t2_valid", va, 1'b1);

    // Pointer wrap past the top index.
    req = 8'h81; rel = 1'b1; tick;
    check("t3_wrap", ga, 8'h01);
    check("t3_wrap_idx", ia, 3'd0);
    tick;
    rel = 1'b0;
    check("t3_back", ga, 8'h80);
    check("t3_back_idx", ia, 3'd7);

    // Hold timeout with MAX_HOLD=4.
    rst = 1'b1; tick;
    rst = 1'b0; req = 8'h03; tick;
    check("t4_grant_c1", gb, 8'h01);
    check("t4_to_c1", tb, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick;
      check("t4_grant", gb, 8'h01);
      check("t4_to", tb, (c == 4) ? 1'b1 : 1'b0);
    end
    tick;
    check("t4_next", gb, 8'h02);
    check("t4_to_after", tb, 1'b0);

    // Reset mid-grant clears state and pointer.
    rst = 1'b1; tick;
    rst = 1'b0; req = 8'h08; tick;
    check("t5_grant", ga, 8'h08);
    rst = 1'b1; tick;
    check("t5_rst_grant", ga, 8'h00);
    check("t5_rst_idx", ia, 3'd0);
    check("t5_rst_valid", va, 1'b0);
    rst = 1'b0; req = 8'hFF; tick;
    check("t5_ptr0", ga, 8'h01);

    // Release while idle, and request dropped while granted.
    rst = 1'b1; tick;
    rst = 1'b0; req = 8'h00; rel = 1'b1; tick;
    check("t6_idle_valid", va, 1'b0);
    check("t6_idle_to", ta, 1'b0);
    rel = 1'b0; req = 8'h10; tick;
    check("t6_grant", ga, 8'h10);
    req = 8'h00;
    tick; tick; tick;
    check("t6_held", ga, 8'h10);
    rel = 1'b1; tick;
    rel = 1'b0;
    check("t6_end_grant", ga, 8'h00);
    check("t6_end_valid", va, 1'b0);
    tick;
    check("t6_stay_idle", va, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      rel = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'($urandom & $urandom);
        default: req = 8'($urandom);
      endcase
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
